// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, read-bridge FSM state type and a constant-width helper
// used by the memory-mapped to stream read bridge.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Bursts must never cross this byte boundary.
    localparam int unsigned AXI_BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } rd_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_mm_axis_reader_if.sv
// Command, AXI4 read (AR/R), AXI-Stream and status signals of the read bridge.
// master is the bridge side, slave is the surrounding system.
interface axi_mm_axis_reader_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 20
);

    logic [ADDR_WIDTH-1:0] s_cmd_addr;
    logic [LEN_WIDTH-1:0]  s_cmd_len;
    logic                  s_cmd_valid;
    logic                  s_cmd_ready;

    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;

    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    logic                  status_done;
    logic                  status_error;

    modport master (
        input  s_cmd_addr, s_cmd_len, s_cmd_valid,
        output s_cmd_ready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready,
        output status_done, status_error
    );

    modport slave (
        output s_cmd_addr, s_cmd_len, s_cmd_valid,
        input  s_cmd_ready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready,
        input  status_done, status_error
    );

endinterface

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice: entry a drives the output, entry b absorbs
// one beat while the sink stalls. in_ready depends only on registered state.
module axis_skid_reg #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
    } beat_t;

    beat_t a_q, a_d, b_q, b_d, in_beat;
    logic  a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic  push, pop;

    assign in_beat  = '{data: in_data, keep: in_keep, last: in_last};
    assign in_ready = !b_valid_q;
    assign push     = in_valid && in_ready;
    assign pop      = a_valid_q && out_ready;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        if (b_valid_q) begin
            // Full: no push possible, b moves up when a leaves.
            if (pop) begin
                a_d       = b_q;
                b_valid_d = 1'b0;
            end
        end else if (a_valid_q) begin
            if (pop && push) begin
                a_d = in_beat;
            end else if (pop) begin
                a_valid_d = 1'b0;
            end else if (push) begin
                b_d       = in_beat;
                b_valid_d = 1'b1;
            end
        end else if (push) begin
            a_d       = in_beat;
            a_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign out_data  = a_q.data;
    assign out_keep  = a_q.keep;
    assign out_last  = a_q.last;
    assign out_valid = a_valid_q;

endmodule

// File: rtl/axi_mm_axis_reader.sv
// AXI4 read bridge: turns a (byte address, byte length) command into INCR bursts
// that never cross 4 KiB, and forwards the read data as one AXI-Stream packet.
module axi_mm_axis_reader
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 34,
    parameter int ID_WIDTH      = 8,
    parameter int LEN_WIDTH     = 20,
    parameter int MAX_BURST_LEN = 16
) (
    input logic                  clk,
    input logic                  rst,
    axi_mm_axis_reader_if.master bus
);

    localparam int ADDR_LSB   = clog2(KEEP_WIDTH);
    localparam int KEEP_CNT_W = ADDR_LSB + 1;

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [LEN_WIDTH-1:0]  burst_q, burst_d;
    logic [LEN_WIDTH-1:0]  burst_left_q, burst_left_d;
    logic [KEEP_CNT_W-1:0] last_keep_q, last_keep_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
    logic [LEN_WIDTH-1:0]  cmd_beats;
    logic [ADDR_LSB-1:0]   cmd_tail;
    logic [KEEP_WIDTH-1:0] last_mask;
    logic                  rd_window, rready, r_beat, beat_last;
    logic                  skid_in_ready, skid_out_valid;

    // Beats allowed in the next burst: remaining, capped by the burst limit and the
    // distance to the next 4 KiB boundary.
    function automatic logic [LEN_WIDTH-1:0] burst_calc(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [LEN_WIDTH-1:0]  rem);
        logic [12:0]          to_bnd;
        logic [LEN_WIDTH-1:0] n;
        to_bnd = (13'(AXI_BOUNDARY_4K) - {1'b0, addr[11:0]}) >> ADDR_LSB;
        n      = rem;
        if (n > LEN_WIDTH'(MAX_BURST_LEN)) n = LEN_WIDTH'(MAX_BURST_LEN);
        if (n > LEN_WIDTH'(to_bnd)) n = LEN_WIDTH'(to_bnd);
        return n;
    endfunction

    assign cmd_addr_aligned = {bus.s_cmd_addr[ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
    assign cmd_tail         = bus.s_cmd_len[ADDR_LSB-1:0];
    assign cmd_beats        = (bus.s_cmd_len >> ADDR_LSB) + LEN_WIDTH'(|cmd_tail);

    always_comb begin
        last_mask = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            last_mask[i] = KEEP_CNT_W'(i) < last_keep_q;
        end
    end

    // R beats are only taken while the current burst still owes data.
    assign rd_window = (state_q == StData) && (burst_left_q != '0);
    assign rready    = rd_window && skid_in_ready;
    assign r_beat    = bus.m_axi_rvalid && rready;
    assign beat_last = rem_q == LEN_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        rem_d        = rem_q;
        burst_d      = burst_q;
        burst_left_d = burst_left_q;
        last_keep_d  = last_keep_q;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.s_cmd_valid) begin
                    cur_addr_d  = cmd_addr_aligned;
                    rem_d       = cmd_beats;
                    last_keep_d = (cmd_tail == '0) ? KEEP_CNT_W'(KEEP_WIDTH)
                                                   : {1'b0, cmd_tail};
                    if (bus.s_cmd_len == '0) begin
                        state_d = StDone;
                    end else begin
                        burst_d = burst_calc(cmd_addr_aligned, cmd_beats);
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (bus.m_axi_arready) begin
                    cur_addr_d   = cur_addr_q + (ADDR_WIDTH'(burst_q) << ADDR_LSB);
                    burst_left_d = burst_q;
                    state_d      = StData;
                end
            end
            StData: begin
                if (r_beat) begin
                    burst_left_d = burst_left_q - LEN_WIDTH'(1);
                    rem_d        = rem_q - LEN_WIDTH'(1);
                    err_d        = err_q || (bus.m_axi_rresp != AXI_RESP_OKAY);
                end else if (burst_left_q == '0) begin
                    if (rem_q != '0) begin
                        burst_d = burst_calc(cur_addr_q, rem_q);
                        state_d = StAddr;
                    end else if (!skid_out_valid) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            rem_q        <= '0;
            burst_q      <= '0;
            burst_left_q <= '0;
            last_keep_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            rem_q        <= rem_d;
            burst_q      <= burst_d;
            burst_left_q <= burst_left_d;
            last_keep_q  <= last_keep_d;
            err_q        <= err_d;
        end
    end

    axis_skid_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (bus.m_axi_rdata),
        .in_keep  (beat_last ? last_mask : {KEEP_WIDTH{1'b1}}),
        .in_last  (beat_last),
        .in_valid (bus.m_axi_rvalid && rd_window),
        .in_ready (skid_in_ready),
        .out_data (bus.m_axis_tdata),
        .out_keep (bus.m_axis_tkeep),
        .out_last (bus.m_axis_tlast),
        .out_valid(skid_out_valid),
        .out_ready(bus.m_axis_tready)
    );

    assign bus.m_axis_tvalid = skid_out_valid;
    assign bus.m_axi_rready  = rready;

    assign bus.s_cmd_ready   = (state_q == StIdle) && !rst;
    assign bus.m_axi_arid    = '0;
    assign bus.m_axi_araddr  = cur_addr_q;
    assign bus.m_axi_arlen   = 8'(burst_q - LEN_WIDTH'(1));
    assign bus.m_axi_arsize  = 3'(ADDR_LSB);
    assign bus.m_axi_arburst = AXI_BURST_INCR;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'h0;
    assign bus.m_axi_arprot  = 3'h0;
    assign bus.m_axi_arvalid = state_q == StAddr;
    assign bus.status_done   = state_q == StDone;
    assign bus.status_error  = (state_q == StDone) && err_q;

    logic unused_ok;
    assign unused_ok = ^{bus.m_axi_rid, bus.m_axi_rlast, bus.s_cmd_addr[ADDR_LSB-1:0]};

endmodule
